// File: rtl/aes_pkg.sv
// Shared AES-128 types, tables and helpers for the key scheduler and the
// cipher / inverse-cipher datapaths.
package aes_pkg;

    typedef logic [127:0] aes_block_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        REV
    } ks_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Rounds outside 1..10 never use a round constant, so they map to zero.
    function automatic aes_word_t rcon_word(input logic [3:0] r);
        if ((r >= 4'd1) && (r <= 4'd10)) begin
            return {RCON[r], 24'h000000};
        end
        return '0;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  aes_word_t word_i,
    output aes_word_t word_o
);

    assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                     SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};

endmodule

// File: rtl/inv_round_key_scheduler.sv
// AES-128 on-the-fly inverse key schedule: optionally expands K0 forward to K10,
// then streams K10 down to K0 over a valid/ready port, one key per cycle.
module inv_round_key_scheduler
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             key_valid_i,
    output logic             key_ready_o,
    input  logic [KEY_W-1:0] key_in_i,
    input  logic             key_is_last_i,
    output logic             rk_valid_o,
    input  logic             rk_ready_i,
    output logic [KEY_W-1:0] rk_data_o,
    output logic [3:0]       rk_idx_o,
    output logic             rk_last_o,
    output logic             busy_o
);

    if ((NR != 10) || (KEY_W != 128)) begin : g_bad_cfg
        $error("inv_round_key_scheduler supports only AES-128 (NR=10, KEY_W=128)");
    end

    ks_state_e  state_q;
    aes_block_t cur_q;
    logic [3:0] rnd_q;
    logic [3:0] idx_q;
    logic       rk_valid_q;
    logic       rk_last_q;
    logic       busy_q;
    logic       key_ready_q;

    aes_word_t  w0, w1, w2, w3;
    aes_word_t  p3;
    aes_word_t  sw_in;
    aes_word_t  sw_out;
    aes_word_t  t_fwd;
    aes_word_t  n0, n1, n2, n3;
    aes_word_t  p0, p1, p2;
    aes_block_t fwd_key_d;
    aes_block_t inv_key_d;

    assign {w0, w1, w2, w3} = cur_q;
    assign p3 = w3 ^ w2;

    // One SubWord serves both directions; only one of them is active at a time.
    assign sw_in = rot_word((state_q == FWD) ? w3 : p3);

    aes_sub_word u_sub_word (
        .word_i (sw_in),
        .word_o (sw_out)
    );

    always_comb begin
        t_fwd     = sw_out ^ rcon_word(rnd_q);
        n0        = w0 ^ t_fwd;
        n1        = w1 ^ n0;
        n2        = w2 ^ n1;
        n3        = w3 ^ n2;
        fwd_key_d = {n0, n1, n2, n3};
        p2        = w2 ^ w1;
        p1        = w1 ^ w0;
        p0        = w0 ^ sw_out ^ rcon_word(idx_q);
        inv_key_d = {p0, p1, p2, p3};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            rnd_q       <= '0;
            idx_q       <= '0;
            rk_valid_q  <= 1'b0;
            rk_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            key_ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_valid_i && key_ready_q) begin
                        cur_q       <= key_in_i;
                        key_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (key_is_last_i) begin
                            idx_q      <= 4'd10;
                            rk_valid_q <= 1'b1;
                            rk_last_q  <= 1'b0;
                            state_q    <= REV;
                        end else begin
                            rnd_q   <= 4'd1;
                            state_q <= FWD;
                        end
                    end
                end
                FWD: begin
                    cur_q <= fwd_key_d;
                    rnd_q <= rnd_q + 4'd1;
                    if (rnd_q == 4'd10) begin
                        idx_q      <= 4'd10;
                        rk_valid_q <= 1'b1;
                        rk_last_q  <= 1'b0;
                        state_q    <= REV;
                    end
                end
                REV: begin
                    if (rk_valid_q && rk_ready_i) begin
                        if (idx_q != 4'd0) begin
                            cur_q     <= inv_key_d;
                            idx_q     <= idx_q - 4'd1;
                            rk_last_q <= (idx_q == 4'd1);
                        end else begin
                            rk_valid_q  <= 1'b0;
                            rk_last_q   <= 1'b0;
                            busy_q      <= 1'b0;
                            key_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign key_ready_o = key_ready_q;
    assign rk_valid_o  = rk_valid_q;
    assign rk_data_o   = cur_q;
    assign rk_idx_o    = idx_q;
    assign rk_last_o   = rk_last_q;
    assign busy_o      = busy_q;

endmodule
